// File: rtl/hls_lock_pkg.sv
// Shared definitions for the key-locked HLS multiply-accumulate controller.
// The DUMMY state exists only when HLS_LOCK_DUMMY_EN is defined.
package hls_lock_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_NUM_LANES = 4;
    localparam int unsigned DEF_KEY_W     = DEF_NUM_LANES + DEF_DATA_W;

    localparam logic [DEF_KEY_W-1:0] DEF_KEY_GOLDEN = '0;

    // Key bits at and above this index mask the result; below it they gate dummy cycles.
    localparam int unsigned KEY_MASK_BASE = DEF_NUM_LANES;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_MAC   = 5'b00100,
`ifdef HLS_LOCK_DUMMY_EN
        ST_DUMMY = 5'b01000,
`endif
        ST_DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/hls_lock_lane_mac.sv
// Shared multiply-add datapath: selects one lane by index and returns acc + a[i]*b[i].
module hls_lock_lane_mac #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned SEL_W     = 3
) (
    input  logic [NUM_LANES*DATA_W-1:0] a_bus,
    input  logic [NUM_LANES*DATA_W-1:0] b_bus,
    input  logic [SEL_W-1:0]            lane_sel,
    input  logic [DATA_W-1:0]           acc,
    output logic [DATA_W-1:0]           sum_c
);

    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_sel == SEL_W'(i)) begin
                a_sel = a_bus[i*DATA_W +: DATA_W];
                b_sel = b_bus[i*DATA_W +: DATA_W];
            end
        end
        sum_c = acc + a_sel * b_sel;
    end

endmodule

// File: rtl/hls_macc_lock_ctrl.sv
// Key-locked multiply-accumulate over NUM_LANES lanes with an HLS ap_ctrl handshake.
// Define HLS_LOCK_DUMMY_EN to insert a corrupting dummy cycle per mismatching lane key bit.
module hls_macc_lock_ctrl
    import hls_lock_pkg::*;
#(
    parameter int unsigned          DATA_W     = DEF_DATA_W,
    parameter int unsigned          NUM_LANES  = DEF_NUM_LANES,
    parameter int unsigned          KEY_W      = NUM_LANES + DATA_W,
    parameter logic [KEY_W-1:0]     KEY_GOLDEN = KEY_W'(DEF_KEY_GOLDEN)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_idle,
    output logic                        ap_ready,
    input  logic [NUM_LANES*DATA_W-1:0] in_a,
    input  logic [NUM_LANES*DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0]           in_c,
    input  logic [KEY_W-1:0]            locking_key,
    output logic [DATA_W-1:0]           out_acc,
    output logic                        out_acc_ap_vld
);

    localparam int unsigned CNT_W  = $clog2(NUM_LANES + 1);
    localparam int unsigned MASK_W = KEY_W - NUM_LANES;

    state_t                      state_q, state_d;
    logic [NUM_LANES*DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0]           c_q, acc_q, mac_sum_c;
    logic [CNT_W-1:0]            lane_q;
    logic [MASK_W-1:0]           wkey_hi_q;
    logic                        done_q;
    logic                        last_lane_c;

    hls_lock_lane_mac #(
        .DATA_W    (DATA_W),
        .NUM_LANES (NUM_LANES),
        .SEL_W     (CNT_W)
    ) u_lane_mac (
        .a_bus    (a_q),
        .b_bus    (b_q),
        .lane_sel (lane_q),
        .acc      (acc_q),
        .sum_c    (mac_sum_c)
    );

    assign last_lane_c = (lane_q == CNT_W'(NUM_LANES - 1));

`ifdef HLS_LOCK_DUMMY_EN
    logic [NUM_LANES-1:0] wkey_lo_q;
    logic                 lane_miss_c;
    logic                 lanes_done_c;

    // Key bit of the lane currently in MAC differs from the golden bit.
    always_comb begin
        lane_miss_c = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == CNT_W'(i)) begin
                lane_miss_c = wkey_lo_q[i] ^ KEY_GOLDEN[i];
            end
        end
    end

    // In DUMMY the counter has already advanced past the lane just processed.
    assign lanes_done_c = (lane_q == CNT_W'(NUM_LANES));
`else
    logic unused_key_lo;
    assign unused_key_lo = ^locking_key[NUM_LANES-1:0];
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ap_start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_MAC;
`ifdef HLS_LOCK_DUMMY_EN
            ST_MAC: begin
                if (lane_miss_c)      state_d = ST_DUMMY;
                else if (last_lane_c) state_d = ST_DONE;
                else                  state_d = ST_MAC;
            end
            ST_DUMMY: state_d = lanes_done_c ? ST_DONE : ST_MAC;
`else
            ST_MAC:   state_d = last_lane_c ? ST_DONE : ST_MAC;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Working registers, accumulator and lane counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            lane_q    <= '0;
            wkey_hi_q <= '0;
`ifdef HLS_LOCK_DUMMY_EN
            wkey_lo_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        c_q       <= in_c;
                        lane_q    <= '0;
                        wkey_hi_q <= locking_key[KEY_W-1:NUM_LANES];
`ifdef HLS_LOCK_DUMMY_EN
                        wkey_lo_q <= locking_key[NUM_LANES-1:0];
`endif
                    end
                end
                ST_LOAD: acc_q <= c_q;
                ST_MAC: begin
                    acc_q  <= mac_sum_c;
                    lane_q <= lane_q + CNT_W'(1);
                end
`ifdef HLS_LOCK_DUMMY_EN
                ST_DUMMY: acc_q <= acc_q ^ c_q;
`endif
                default: ;
            endcase
        end
    end

    assign ap_done        = done_q;
    assign ap_ready       = done_q;
    assign out_acc_ap_vld = done_q;
    assign ap_idle        = (state_q == ST_IDLE) && !ap_start;
    assign out_acc        = acc_q ^ DATA_W'(wkey_hi_q ^ KEY_GOLDEN[KEY_W-1:NUM_LANES]);

endmodule
